ifu_pc_gen: RTL and testbench

IFU_PC_GEN -- requirements
Module: ifu_pc_gen

---
 rtl/ifu_pc_gen.sv | 100 ++++++++++
 tb/tb_ifu_pc_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - instruction fetch PC generator with one-entry pending redirect
//
// Purpose: holds the fetch PC and picks the next one. Priority is flush, then PC
//          hold, then a pending redirect, then jump, then sequential PC+4. A jump
//          that arrives while the PC is held is saved and applied on the first
//          unheld edge. The fetch address is the PC with the kseg0/kseg1 window
//          folded down to physical.
// Ports:
//   cpu_clk_50M    in   1  clock, rising edge
//   cpu_rst        in   1  asynchronous active-high reset
//   stall          in   6  stall bus; bit0 holds the PC, bit1 is IF/ID only
//   flush          in   1  exception/eret redirect
//   flush_pc       in  32  redirect target, valid with flush
//   jump_flag      in   1  branch/jump taken (resolved in ID)
//   jump_addr      in  32  branch/jump target
//   if_pc          out 32  current fetch PC
//   if_exccode     out  5  fetch exception code (5'h10 = none)
//   inst_sram_en   out  1  instruction SRAM read enable
//   inst_sram_addr out 32  physical fetch address
// Build option: IFU_ADEL_CHECK_EN enables misaligned-fetch (AdEL) detection.

module ifu_pc_gen (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    output logic [31:0] if_pc,
    output logic [4:0]  if_exccode,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr
);

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [4:0]  EXC_NONE = 5'h10;
`ifdef IFU_ADEL_CHECK_EN
    localparam logic [4:0]  EXC_ADEL = 5'h04;
`endif

    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        fetch_exc;

    // Only bit0 of the stall bus concerns this stage.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    always_comb begin
        pc_d         = pc_q + 32'd4;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (flush) begin
            // A flush overrides everything and drops any saved redirect.
            pc_d         = flush_pc;
            pend_valid_d = 1'b0;
        end else if (stall[0]) begin
            pc_d = pc_q;
            // First captured target wins; later jumps during the hold are lost.
            if (jump_flag && !pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = jump_addr;
            end
        end else if (pend_valid_q) begin
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
        end else if (jump_flag) begin
            pc_d = jump_addr;
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

`ifdef IFU_ADEL_CHECK_EN
    assign fetch_exc  = (pc_q[1:0] != 2'b00);
    assign if_exccode = fetch_exc ? EXC_ADEL : EXC_NONE;
`else
    assign fetch_exc  = 1'b0;
    assign if_exccode = EXC_NONE;
`endif

    assign if_pc        = pc_q;
    assign inst_sram_en = !cpu_rst && !flush && !fetch_exc;

    // kseg0 (100) and kseg1 (101) both map onto the low 512 MB of physical space.
    assign inst_sram_addr = (pc_q[31:30] == 2'b10) ? {3'b000, pc_q[28:0]} : pc_q;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// tb/tb_ifu_pc_gen.sv - scoreboard testbench for ifu_pc_gen

module tb_ifu_pc_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [31:0] if_pc;
    logic [4:0]  if_exccode;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;

`ifdef IFU_ADEL_CHECK_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        en;
        logic [4:0]  exc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    ifu_pc_gen dut (
        .cpu_clk_50M    (clk),
        .cpu_rst        (rst),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .jump_flag      (jump_flag),
        .jump_addr      (jump_addr),
        .if_pc          (if_pc),
        .if_exccode     (if_exccode),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Monitor: outputs are compared mid-cycle, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".pc"},   if_pc,                  e.pc);
                chk({e.name, ".addr"}, inst_sram_addr,         e.addr);
                chk({e.name, ".en"},   {31'd0, inst_sram_en},  {31'd0, e.en});
                chk({e.name, ".exc"},  {27'd0, if_exccode},    {27'd0, e.exc});
            end
        end
    end

    // Apply inputs for one cycle and queue the outputs expected during that cycle.
    task automatic vec(input string name, input logic r, input logic [5:0] st,
                       input logic fl, input logic [31:0] fpc,
                       input logic jf, input logic [31:0] ja,
                       input logic [31:0] e_pc, input logic [31:0] e_addr,
                       input logic e_en, input logic [4:0] e_exc);
        exp_t e;
        rst = r; stall = st; flush = fl; flush_pc = fpc; jump_flag = jf; jump_addr = ja;
        e.name = name; e.pc = e_pc; e.addr = e_addr; e.en = e_en; e.exc = e_exc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 6'd0; flush = 1'b0; flush_pc = 32'd0;
        jump_flag = 1'b0; jump_addr = 32'd0;
        @(posedge clk);
        #1;
        //   name        rst stall  fl flush_pc      jf jump_addr     pc            addr          en exc
        vec("reset",     1, 6'h00, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 32'h1FC00000, 0, 5'h10);
        vec("boot0",     0, 6'h00, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 32'h1FC00000, 1, 5'h10);
        vec("boot1",     0, 6'h00, 0, 32'h0,        0, 32'h0,        32'hBFC00004, 32'h1FC00004, 1, 5'h10);
        vec("boot2_jmp", 0, 6'h00, 0, 32'h0,        1, 32'h80001000, 32'hBFC00008, 32'h1FC00008, 1, 5'h10);
        vec("jmp_k0",    0, 6'h00, 0, 32'h0,        0, 32'h0,        32'h80001000, 32'h00001000, 1, 5'h10);
        vec("stall_j1",  0, 6'h01, 0, 32'h0,        1, 32'hBFC00100, 32'h80001004, 32'h00001004, 1, 5'h10);
        vec("stall_j2",  0, 6'h01, 0, 32'h0,        1, 32'h12345678, 32'h80001004, 32'h00001004, 1, 5'h10);
        vec("stall_3",   0, 6'h01, 0, 32'h0,        0, 32'h0,        32'h80001004, 32'h00001004, 1, 5'h10);
        vec("unstall",   0, 6'h00, 0, 32'h0,        0, 32'h0,        32'h80001004, 32'h00001004, 1, 5'h10);
        vec("pend_tgt",  0, 6'h00, 0, 32'h0,        0, 32'h0,        32'hBFC00100, 32'h1FC00100, 1, 5'h10);
        vec("flush_all", 0, 6'h01, 1, 32'hBFC00380, 1, 32'h80002000, 32'hBFC00104, 32'h1FC00104, 0, 5'h10);
        vec("flush_tgt", 0, 6'h00, 0, 32'h0,        0, 32'h0,        32'hBFC00380, 32'h1FC00380, 1, 5'h10);
        vec("no_pend",   0, 6'h02, 0, 32'h0,        0, 32'h0,        32'hBFC00384, 32'h1FC00384, 1, 5'h10);
        vec("ifid_only", 0, 6'h00, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hBFC00388, 32'h1FC00388, 1, 5'h10);
        vec("top_pc",    0, 6'h00, 0, 32'h0,        0, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 1, 5'h10);
        vec("wrap",      0, 6'h00, 0, 32'h0,        1, 32'hA0000010, 32'h00000000, 32'h00000000, 1, 5'h10);
        vec("kseg1",     0, 6'h00, 0, 32'h0,        1, 32'h80000002, 32'hA0000010, 32'h00000010, 1, 5'h10);
        vec("mis0",      0, 6'h00, 0, 32'h0,        0, 32'h0,        32'h80000002, 32'h00000002, !ADEL, ADEL ? 5'h04 : 5'h10);
        vec("mis1_stl",  0, 6'h01, 0, 32'h0,        1, 32'h80004000, 32'h80000006, 32'h00000006, !ADEL, ADEL ? 5'h04 : 5'h10);
        vec("pend_hold", 0, 6'h01, 0, 32'h0,        0, 32'h0,        32'h80000006, 32'h00000006, !ADEL, ADEL ? 5'h04 : 5'h10);
        // Reset raised 1 time unit after the edge: PC must already be the reset vector at mid-cycle.
        vec("rst_mid",   1, 6'h00, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 32'h1FC00000, 0, 5'h10);
        vec("rst_rel",   0, 6'h00, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 32'h1FC00000, 1, 5'h10);
        vec("pend_gone", 0, 6'h00, 0, 32'h0,        0, 32'h0,        32'hBFC00004, 32'h1FC00004, 1, 5'h10);
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
